// File: rtl/rgb_to_yuv422.sv
// RGB888 to BT.601 limited-range 10-bit YUV 4:2:2, four register stages gated by cke.
// Chroma of each pixel pair is optionally averaged; hs/vs ride a matching delay line.
module rgb_to_yuv422 #(
   parameter int CHROMA_AVG = 1,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cke,
   input  logic        rgb_hs,
   input  logic        rgb_vs,
   input  logic        rgb_de,
   input  logic [23:0] rgb_dat,
   output logic        yuv_hs,
   output logic        yuv_vs,
   output logic        yuv_de,
   output logic [9:0]  yuv_y,
   output logic [9:0]  yuv_c
);
   typedef logic signed [19:0] prod_t;
   typedef logic signed [11:0] sum_t;

   localparam prod_t K_YR  = 20'sd263;
   localparam prod_t K_YG  = 20'sd516;
   localparam prod_t K_YB  = 20'sd100;
   localparam prod_t K_CBR = -20'sd152;
   localparam prod_t K_CBG = -20'sd298;
   localparam prod_t K_CBB = 20'sd450;
   localparam prod_t K_CRR = 20'sd450;
   localparam prod_t K_CRG = -20'sd377;
   localparam prod_t K_CRB = -20'sd73;
   localparam prod_t K_RND = 20'sd128;
   localparam prod_t K_OFY = 20'sd64;
   localparam prod_t K_OFC = 20'sd512;

   function automatic logic [9:0] clamp(input sum_t v, input sum_t lo, input sum_t hi);
      logic [9:0] res;
      if (v < lo)      res = lo[9:0];
      else if (v > hi) res = hi[9:0];
      else             res = v[9:0];
      return res;
   endfunction

   function automatic logic [9:0] avg2(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] s;
      s = {1'b0, a} + {1'b0, b} + 11'd1;
      return s[10:1];
   endfunction

   logic                 seen_low_q, seen_low_d;
   logic [2*LATENCY-1:0] hv_q, hv_d;
   prod_t                prod_q [9];
   prod_t                prod_d [9];
   logic                 de1_q, de1_d, de2_q, de2_d, de3_q, de3_d, de4_q, de4_d;
   sum_t                 y2_q, y2_d, cb2_q, cb2_d, cr2_q, cr2_d;
   logic [9:0]           y3_q, y3_d, cb3_q, cb3_d, cr3_q, cr3_d;
   logic [9:0]           y4_q, y4_d, c4_q, c4_d, cr_st_q, cr_st_d;
   logic                 phase_q, phase_d;
   prod_t                r, g, b, sum_y, sum_cb, sum_cr;
   logic                 is_even;

   // After reset, de stays masked until the input has been seen low, so a line
   // interrupted by reset is dropped and output restarts on the next de rise.
   always_comb begin
      r          = {12'd0, rgb_dat[23:16]};
      g          = {12'd0, rgb_dat[15:8]};
      b          = {12'd0, rgb_dat[7:0]};
      prod_d[0]  = r * K_YR;
      prod_d[1]  = g * K_YG;
      prod_d[2]  = b * K_YB;
      prod_d[3]  = r * K_CBR;
      prod_d[4]  = g * K_CBG;
      prod_d[5]  = b * K_CBB;
      prod_d[6]  = r * K_CRR;
      prod_d[7]  = g * K_CRG;
      prod_d[8]  = b * K_CRB;
      de1_d      = rgb_de & seen_low_q;
      seen_low_d = seen_low_q | ~rgb_de;
      hv_d       = {hv_q[2*LATENCY-3:0], rgb_hs, rgb_vs};
   end

   always_comb begin
      sum_y  = prod_q[0] + prod_q[1] + prod_q[2] + K_RND;
      sum_cb = prod_q[3] + prod_q[4] + prod_q[5] + K_RND;
      sum_cr = prod_q[6] + prod_q[7] + prod_q[8] + K_RND;
      y2_d   = sum_t'(K_OFY + (sum_y >>> 8));
      cb2_d  = sum_t'(K_OFC + (sum_cb >>> 8));
      cr2_d  = sum_t'(K_OFC + (sum_cr >>> 8));
      de2_d  = de1_q;
      y3_d   = clamp(y2_q, 12'sd64, 12'sd940);
      cb3_d  = clamp(cb2_q, 12'sd64, 12'sd960);
      cr3_d  = clamp(cr2_q, 12'sd64, 12'sd960);
      de3_d  = de2_q;
   end

   // Output stage: the even pixel sits in S3 while its odd successor is being clamped
   // from S2, so the pair's Cb can be averaged without an extra stage of latency.
   always_comb begin
      is_even = ~de4_q | ~phase_q;
      de4_d   = de3_q;
      y4_d    = 10'd64;
      c4_d    = 10'd512;
      phase_d = phase_q;
      cr_st_d = cr_st_q;
      if (de3_q) begin
         y4_d = y3_q;
         if (is_even) begin
            phase_d = 1'b1;
            cr_st_d = cr3_q;
            c4_d    = (CHROMA_AVG != 0 && de2_q) ? avg2(cb3_q, cb3_d) : cb3_q;
         end else begin
            phase_d = 1'b0;
            c4_d    = (CHROMA_AVG != 0) ? avg2(cr_st_q, cr3_q) : cr_st_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen_low_q <= 1'b0;
         hv_q       <= '0;
         prod_q     <= '{default: '0};
         de1_q      <= 1'b0;
         de2_q      <= 1'b0;
         de3_q      <= 1'b0;
         de4_q      <= 1'b0;
         y2_q       <= '0;
         cb2_q      <= '0;
         cr2_q      <= '0;
         y3_q       <= '0;
         cb3_q      <= '0;
         cr3_q      <= '0;
         y4_q       <= '0;
         c4_q       <= '0;
         cr_st_q    <= '0;
         phase_q    <= 1'b0;
      end else if (cke) begin
         seen_low_q <= seen_low_d;
         hv_q       <= hv_d;
         prod_q     <= prod_d;
         de1_q      <= de1_d;
         de2_q      <= de2_d;
         de3_q      <= de3_d;
         de4_q      <= de4_d;
         y2_q       <= y2_d;
         cb2_q      <= cb2_d;
         cr2_q      <= cr2_d;
         y3_q       <= y3_d;
         cb3_q      <= cb3_d;
         cr3_q      <= cr3_d;
         y4_q       <= y4_d;
         c4_q       <= c4_d;
         cr_st_q    <= cr_st_d;
         phase_q    <= phase_d;
      end
   end

   assign yuv_hs = hv_q[2*LATENCY-1];
   assign yuv_vs = hv_q[2*LATENCY-2];
   assign yuv_de = de4_q;
   assign yuv_y  = y4_q;
   assign yuv_c  = c4_q;

endmodule
